// File: rtl/exc_redirect_ctrl.sv
// rtl/exc_redirect_ctrl.sv - exception redirect sequencer: drains outstanding fetches, then strobes the new PC.
// Optional drain watchdog enabled by defining REDIRECT_TIMEOUT_EN.
`timescale 1ns/1ps
module exc_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        fetch_fire,
  input  logic        inst_sram_data_ok,
  output logic        flush,
  output logic        fetch_block,
  output logic        discard_data,
  output logic        pc_redirect_valid,
  output logic [31:0] pc_redirect,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx, cnt_d;
  logic [31:0] target;
  logic        latch;
  logic        wd_fire;

  // Simultaneous issue and return cancel; data_ok with nothing outstanding is dropped.
  always_comb begin
    cnt_nx = cnt;
    if (fetch_fire && !inst_sram_data_ok && cnt != 2'd3)
      cnt_nx = cnt + 2'd1;
    else if (!fetch_fire && inst_sram_data_ok && cnt != 2'd0)
      cnt_nx = cnt - 2'd1;
  end

`ifdef REDIRECT_TIMEOUT_EN
  logic [7:0] wd;
  logic       timeout_q;

  assign wd_fire = (state == DRAIN) && (wd == 8'hff);

  // Counter sits at zero outside DRAIN, so DRAIN entry always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd        <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      if (state != DRAIN || inst_sram_data_ok || wd_fire)
        wd <= 8'd0;
      else
        wd <= wd + 8'd1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign cnt_d = wd_fire ? 2'd0 : cnt_nx;

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    case (state)
      IDLE: begin
        if (exc_valid) begin
          latch    = 1'b1;
          state_nx = (cnt_nx == 2'd0) ? REDIRECT : DRAIN;
        end
      end
      DRAIN: begin
        latch = exc_valid;
        // A fresh request keeps us draining one more cycle so its target is the one issued.
        if (wd_fire || (!exc_valid && cnt_nx == 2'd0))
          state_nx = REDIRECT;
      end
      REDIRECT: begin
        latch    = exc_valid;
        state_nx = exc_valid ? REDIRECT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      target <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_d;
      if (latch)
        target <= exc_target;
    end
  end

  assign flush             = (state != IDLE);
  assign fetch_block       = (state != IDLE) || (cnt == 2'd3);
  assign discard_data      = (state == DRAIN) && inst_sram_data_ok;
  assign pc_redirect_valid = (state == REDIRECT);
  assign pc_redirect       = target;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// tb/tb_exc_redirect_ctrl.sv - self-checking bench for exc_redirect_ctrl (vector table, corner sequences, random vs model).
`timescale 1ns/1ps
module tb_exc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [31:0] exc_target;
  logic        fetch_fire;
  logic        inst_sram_data_ok;
  logic        flush, fetch_block, discard_data, pc_redirect_valid, timeout_err;
  logic [31:0] pc_redirect;

  int errors = 0;
  int checks = 0;

  exc_redirect_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .exc_valid         (exc_valid),
    .exc_target        (exc_target),
    .fetch_fire        (fetch_fire),
    .inst_sram_data_ok (inst_sram_data_ok),
    .flush             (flush),
    .fetch_block       (fetch_block),
    .discard_data      (discard_data),
    .pc_redirect_valid (pc_redirect_valid),
    .pc_redirect       (pc_redirect),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [31:0] tgt;
    logic        ff;
    logic        ok;
    logic [3:0]  exp;   // {flush, fetch_block, discard_data, pc_redirect_valid}
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[15];

  // Reference model: outstanding count plus request phase (0 none, 1 waiting, 2 strobe).
  int          m_cnt;
  int          m_phase;
  logic [31:0] m_tgt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] t, input logic ff, input logic ok);
    exc_valid         = ev;
    exc_target        = t;
    fetch_fire        = ff;
    inst_sram_data_ok = ok;
  endtask

  function automatic logic [3:0] outs();
    return {flush, fetch_block, discard_data, pc_redirect_valid};
  endfunction

  function automatic void model_reset();
    m_cnt   = 0;
    m_phase = 0;
    m_tgt   = 32'd0;
  endfunction

  task automatic model_check(input string nm);
    logic [4:0] e;
    e[4] = (m_phase != 0);
    e[3] = (m_phase != 0) || (m_cnt == 3);
    e[2] = (m_phase == 1) && inst_sram_data_ok;
    e[1] = (m_phase == 2);
    e[0] = 1'b0;
    chk({nm, "_outs"}, {27'd0, outs(), timeout_err}, {27'd0, e});
    chk({nm, "_pc"}, pc_redirect, m_tgt);
  endtask

  task automatic model_step();
    int n;
    if (rst) begin
      model_reset();
      return;
    end
    n = m_cnt;
    if (fetch_fire && !inst_sram_data_ok) n = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
    if (inst_sram_data_ok && !fetch_fire) n = (m_cnt - 1 < 0) ? 0 : m_cnt - 1;
    if (exc_valid) begin
      m_tgt = exc_target;
      if (m_phase == 0) m_phase = (n == 0) ? 2 : 1;
    end else if (m_phase == 1) begin
      if (n == 0) m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
    m_cnt = n;
  endtask

  initial begin
    int strobes;
    int seen;
    logic [31:0] spc;

    tbl[0]  = '{1'b1, 32'hBFC00380, 1'b0, 1'b0, 4'b0000, 32'h00000000};
    tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'b1101, 32'hBFC00380};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'hBFC00380};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'hBFC00380};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'hBFC00380};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'hBFC00380};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'b0100, 32'hBFC00380};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 4'b0100, 32'hBFC00380};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'hBFC00380};
    tbl[9]  = '{1'b1, 32'h80000040, 1'b0, 1'b0, 4'b0000, 32'hBFC00380};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'b1100, 32'h80000040};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 4'b1110, 32'h80000040};
    tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b1, 4'b1110, 32'h80000040};
    tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'b1101, 32'h80000040};
    tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'b0000, 32'h80000040};

    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {28'd0, outs()}, 32'd0);
    chk("reset_pc", pc_redirect, 32'd0);
    chk("reset_timeout", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].ev, tbl[i].tgt, tbl[i].ff, tbl[i].ok);
      #1;
      chk($sformatf("vec%0d_outs", i), {28'd0, outs()}, {28'd0, tbl[i].exp});
      chk($sformatf("vec%0d_pc", i), pc_redirect, tbl[i].pc);
      @(negedge clk);
    end

    // Latest request during DRAIN wins, with a single strobe.
    drive(1'b0, 32'h0, 1'b1, 1'b0); @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0); @(negedge clk);
    drive(1'b1, 32'hBFC00380, 1'b0, 1'b0); @(negedge clk);
    drive(1'b1, 32'h80001000, 1'b0, 1'b0); #1;
    chk("latest_drain_flush", {31'd0, flush}, 32'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1); @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1); @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    strobes = 0;
    spc = 32'd0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (pc_redirect_valid) begin strobes++; spc = pc_redirect; end
      @(negedge clk);
    end
    chk("latest_strobe_count", strobes, 1);
    chk("latest_strobe_pc", spc, 32'h80001000);

    // Back-to-back request while in REDIRECT extends it by one cycle.
    drive(1'b1, 32'h11112220, 1'b0, 1'b0); @(negedge clk);
    drive(1'b1, 32'h33334440, 1'b0, 1'b0); #1;
    chk("relatch_first", {pc_redirect_valid, pc_redirect}, {1'b1, 32'h11112220});
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("relatch_second", {pc_redirect_valid, pc_redirect}, {1'b1, 32'h33334440});
    @(negedge clk);
    #1;
    chk("relatch_done", {28'd0, outs()}, 32'd0);
    @(negedge clk);

    // Reset mid-DRAIN abandons the sequence at once.
    drive(1'b0, 32'h0, 1'b1, 1'b0); @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0); @(negedge clk);
    drive(1'b1, 32'h9000ABC0, 1'b0, 1'b0); @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1); #1;
    chk("rst_pre_drain", {28'd0, outs()}, 32'b1110);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs", {28'd0, outs()}, 32'd0);
    chk("rst_async_pc", pc_redirect, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b0, i[0]);
      #1;
      if (pc_redirect_valid || flush || fetch_block) seen++;
      @(negedge clk);
    end
    chk("rst_no_strobe_after", seen, 0);

`ifdef REDIRECT_TIMEOUT_EN
    drive(1'b0, 32'h0, 1'b1, 1'b0); @(negedge clk);
    drive(1'b1, 32'hBFC00200, 1'b0, 1'b0); @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    seen = 0;
    for (int n = 1; n < 400 && seen == 0; n++) begin
      #1;
      if (timeout_err) begin
        seen = n;
        chk("wd_strobe_with_timeout", {31'd0, pc_redirect_valid}, 32'd1);
      end
      @(negedge clk);
    end
    chk("wd_fired_in_window", {31'd0, (seen >= 250 && seen <= 260)}, 32'd1);
    #1;
    chk("wd_pulse_one_cycle", {31'd0, timeout_err}, 32'd0);
    chk("wd_cnt_cleared", {31'd0, fetch_block}, 32'd0);
    @(negedge clk);
`else
    drive(1'b0, 32'h0, 1'b1, 1'b0); @(negedge clk);
    drive(1'b1, 32'hBFC00200, 1'b0, 1'b0); @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    seen = 0;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (!flush || timeout_err || pc_redirect_valid) seen++;
      @(negedge clk);
    end
    chk("drain_waits_forever", seen, 0);
    drive(1'b0, 32'h0, 1'b0, 1'b1); @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
    chk("drain_release_strobe", {pc_redirect_valid, pc_redirect}, {1'b1, 32'hBFC00200});
    @(negedge clk);
`endif

    // Random traffic against the reference model; start from a clean reset.
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) model_reset();
      drive(($urandom_range(0, 11) == 0), $urandom,
            ((m_phase == 0) && (m_cnt != 3) && $urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) == 0));
      #1;
      model_check($sformatf("rand%0d", c));
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_redirect_ctrl.md
EXC_REDIRECT_CTRL -- requirements
Module: exc_redirect_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-003 SHALL have port exc_valid, input, 1, a pulse from the exception unit requesting a redirect (exception, interrupt or eret).
REQ-004 SHALL have port exc_target, input, 32, the redirect PC, valid when exc_valid=1.
REQ-005 SHALL have port fetch_fire, input, 1, indicating an instruction fetch was accepted this cycle (inst_sram_req & inst_sram_addr_ok).
REQ-006 SHALL have port inst_sram_data_ok, input, 1, indicating a fetch response returned this cycle.
REQ-007 SHALL have port flush, output, 1, the pipeline flush while a redirect sequence is active.
REQ-008 SHALL have port fetch_block, output, 1, which forbids the fetch stage from issuing new requests.
REQ-009 SHALL have port discard_data, output, 1, marking the returned fetch data as stale so it is dropped.
REQ-010 SHALL have port pc_redirect_valid, output, 1, a one-cycle strobe that loads pc_redirect into the PC.
REQ-011 SHALL have port pc_redirect, output, 32, the latched redirect target.
REQ-012 SHALL have port timeout_err, output, 1, a one-cycle pulse when the drain watchdog fires (REQ-030).

Function
REQ-013 SHALL keep a 2-bit outstanding-fetch counter cnt: +1 on fetch_fire only, -1 on data_ok only, unchanged when both or neither occur.
REQ-014 SHALL ignore data_ok when cnt=0 (no underflow); cnt SHALL never exceed 3.
REQ-015 SHALL define the next-count value cnt_nx as cnt after this cycle's fire/data_ok update.
REQ-016 SHALL implement an FSM with states IDLE, DRAIN and REDIRECT.
REQ-017 In IDLE with exc_valid=1, SHALL latch exc_target and go to REDIRECT if cnt_nx=0, else to DRAIN.
REQ-018 In DRAIN, SHALL go to REDIRECT on the edge where cnt_nx=0.
REQ-019 In DRAIN, exc_valid=1 SHALL overwrite the latched target (latest request wins) and the FSM SHALL stay in DRAIN.
REQ-020 SHALL stay in REDIRECT for exactly one cycle, then go to IDLE.
REQ-021 exc_valid=1 in REDIRECT SHALL relatch the target and the FSM SHALL remain in REDIRECT one more cycle.
REQ-022 Outputs SHALL be decoded from registered state: flush = (state != IDLE).
REQ-023 fetch_block SHALL equal (state != IDLE) | (cnt = 3).
REQ-024 discard_data SHALL equal (state = DRAIN) & inst_sram_data_ok.
REQ-025 pc_redirect_valid SHALL equal (state = REDIRECT); pc_redirect SHALL be the latched target.
REQ-026 Latency: exc_valid sampled at edge T with cnt_nx=0 -> pc_redirect_valid and flush high in cycle T+1, and flush low in cycle T+2 unless a new request arrives.
REQ-027 fetch_fire while fetch_block=1 is a protocol error; cnt SHALL still saturate at 3 and this case SHALL not be checked further.

Reset
REQ-028 While rst=1, SHALL hold state=IDLE, cnt=0 and target=0, with all outputs 0 except fetch_block=0.
REQ-029 Reset asserted mid-sequence SHALL abandon the sequence immediately; no pc_redirect_valid is issued after reset release.

Configuration
REQ-030 With macro REDIRECT_TIMEOUT_EN defined, SHALL run an 8-bit watchdog that clears on DRAIN entry and on every data_ok, and increments each DRAIN cycle otherwise.
REQ-031 When the watchdog reaches 255, SHALL force cnt=0, go to REDIRECT and pulse timeout_err for one cycle.
REQ-032 Without REDIRECT_TIMEOUT_EN, there SHALL be no watchdog logic, timeout_err SHALL be tied 0 and DRAIN SHALL wait indefinitely.

Verification
REQ-033 cnt=0, exc_valid with target 0xBFC00380 -> next cycle: flush=1, pc_redirect_valid=1, pc_redirect=0xBFC00380; the cycle after: flush=0.
REQ-034 cnt=2, exc_valid -> DRAIN: flush=1, fetch_block=1; the two data_ok responses each assert discard_data; pc_redirect_valid rises the cycle after the second data_ok.
REQ-035 DRAIN with target 0xBFC00380, then exc_valid with target 0x80001000 -> the single pc_redirect_valid carries 0x80001000.
REQ-036 IDLE with three fetch_fire and no data_ok -> cnt=3 and fetch_block=1; one data_ok -> fetch_block=0.
REQ-037 rst asserted in DRAIN with cnt=2 -> outputs 0 immediately; after release no redirect strobe appears.
REQ-038 With REDIRECT_TIMEOUT_EN: DRAIN with cnt=1 and no data_ok for 255 cycles -> timeout_err pulse and pc_redirect_valid in the next cycle.
